// File: rtl/object_pkg.sv
// Shared types and defaults for the sprite position movers.
//   dir_t      : movement direction encoding
//   state_t    : mover FSM states
//   opposite() : reverse of a direction
package object_pkg;

    localparam int unsigned POS_W        = 11;
    localparam int unsigned CALC_W       = 12;
    localparam int unsigned SCREEN_W_DEF = 640;
    localparam int unsigned SCREEN_H_DEF = 480;
    localparam int unsigned TILE_DEF     = 16;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_BLOCKED
    } state_t;

    function automatic dir_t opposite(input dir_t d);
        dir_t r;
        r = d;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/object_mover_if.sv
// Control/position bundle between game control, the mover and the drawing pipeline.
//   master : game control side (drives enable/frame/collision/requests, reads position)
//   slave  : object_mover side
interface object_mover_if;
    import object_pkg::*;

    logic                           enable;
    logic                           start_of_frame;
    logic                           collision;
    dir_t                           dir_req;
    logic                           dir_req_valid;
    logic signed [POS_W-1:0]        top_left_x;
    logic signed [POS_W-1:0]        top_left_y;
    dir_t                           cur_dir;
    logic                           moving;
    logic                           hit_pulse;

    modport master (
        output enable, start_of_frame, collision, dir_req, dir_req_valid,
        input  top_left_x, top_left_y, cur_dir, moving, hit_pulse
    );

    modport slave (
        input  enable, start_of_frame, collision, dir_req, dir_req_valid,
        output top_left_x, top_left_y, cur_dir, moving, hit_pulse
    );
endinterface

// File: rtl/object_step_calc.sv
// One-frame step of a sprite position: moves SPEED pixels along i_dir,
// wraps x through the horizontal tunnel and clamps y to the screen.
//   i_x, i_y      : current top-left position (signed)
//   i_dir         : direction to step in
//   o_x_c, o_y_c  : stepped position
//   o_wrapped_c   : x crossed the tunnel this step
//   o_clamped_c   : y hit a screen edge (step counts as blocked)
module object_step_calc
    import object_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = 16,
    parameter int OBJECT_HEIGHT_Y = 16,
    parameter int SPEED           = 2,
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480
) (
    input  logic signed [POS_W-1:0] i_x,
    input  logic signed [POS_W-1:0] i_y,
    input  dir_t                    i_dir,
    output logic signed [POS_W-1:0] o_x_c,
    output logic signed [POS_W-1:0] o_y_c,
    output logic                    o_wrapped_c,
    output logic                    o_clamped_c
);

    localparam logic signed [CALC_W-1:0] C_SPEED = CALC_W'(SPEED);
    localparam logic signed [CALC_W-1:0] C_XMAX  = CALC_W'(SCREEN_W);
    localparam logic signed [CALC_W-1:0] C_XMIN  = CALC_W'(-OBJECT_WIDTH_X);
    localparam logic signed [CALC_W-1:0] C_WRAP  = CALC_W'(SCREEN_W + OBJECT_WIDTH_X);
    localparam logic signed [CALC_W-1:0] C_YMAX  = CALC_W'(SCREEN_H - OBJECT_HEIGHT_Y);
    localparam logic signed [CALC_W-1:0] C_ZERO  = '0;

    logic signed [CALC_W-1:0] w_x;
    logic signed [CALC_W-1:0] w_y;

    // Step, then tunnel-wrap x and clamp y in the wider signed domain
    always_comb begin
        w_x         = {i_x[POS_W-1], i_x};
        w_y         = {i_y[POS_W-1], i_y};
        o_wrapped_c = 1'b0;
        o_clamped_c = 1'b0;

        case (i_dir)
            DIR_UP:    w_y = w_y - C_SPEED;
            DIR_DOWN:  w_y = w_y + C_SPEED;
            DIR_LEFT:  w_x = w_x - C_SPEED;
            DIR_RIGHT: w_x = w_x + C_SPEED;
            default:   ;
        endcase

        if (w_x >= C_XMAX) begin
            w_x         = w_x - C_WRAP;
            o_wrapped_c = 1'b1;
        end else if (w_x < C_XMIN) begin
            w_x         = w_x + C_WRAP;
            o_wrapped_c = 1'b1;
        end

        if (w_y < C_ZERO) begin
            w_y         = C_ZERO;
            o_clamped_c = 1'b1;
        end else if (w_y > C_YMAX) begin
            w_y         = C_YMAX;
            o_clamped_c = 1'b1;
        end

        o_x_c = POS_W'(w_x);
        o_y_c = POS_W'(w_y);
    end

endmodule

// File: rtl/object_mover.sv
// Holds one sprite's position and steps it once per video frame.
// Applies joystick turns at tile-aligned positions (reversals at once),
// reverts the last step after a wall collision and wraps through the tunnel.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : object_mover_if.slave (enable, frame pulse, collision,
//                direction request in; position, direction, moving, hit out)
module object_mover
    import object_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = 16,
    parameter int OBJECT_HEIGHT_Y = 16,
    parameter int INIT_X          = 304,
    parameter int INIT_Y          = 352,
    parameter int SPEED           = 2,
    parameter int TILE            = int'(TILE_DEF),
    parameter int SCREEN_W        = int'(SCREEN_W_DEF),
    parameter int SCREEN_H        = int'(SCREEN_H_DEF)
) (
    input  logic           clk,
    input  logic           reset,
    object_mover_if.slave  bus
);

    localparam int unsigned TILE_BITS = $clog2(TILE);

    state_t                  r_state, w_state_nxt;
    logic signed [POS_W-1:0] r_x, r_y, r_px, r_py;
    logic signed [POS_W-1:0] w_x_nxt, w_y_nxt, w_px_nxt, w_py_nxt;
    dir_t                    r_dir, w_dir_nxt;
    dir_t                    r_pend_dir, w_pend_dir_nxt;
    logic                    r_pend_valid, w_pend_valid_nxt;
    logic                    r_flag, w_flag_nxt;
    logic                    r_hit, w_hit_nxt;

    logic                    w_pend_valid;
    dir_t                    w_pend_dir;
    logic                    w_flag;
    logic                    w_aligned;
    logic                    w_turn;
    dir_t                    w_step_dir;
    logic signed [POS_W-1:0] w_step_x, w_step_y;
    logic                    w_wrapped, w_clamped;

    // A request arriving this cycle overrides the latched one and counts now
    assign w_pend_valid = r_pend_valid | bus.dir_req_valid;
    assign w_pend_dir   = bus.dir_req_valid ? bus.dir_req : r_pend_dir;
    // Collision coincident with the frame pulse belongs to the ending frame
    assign w_flag       = r_flag | bus.collision;
    assign w_aligned    = (r_x[TILE_BITS-1:0] == '0) && (r_y[TILE_BITS-1:0] == '0);
    assign w_turn       = w_pend_valid && ((w_pend_dir == opposite(r_dir)) || w_aligned);
    assign w_step_dir   = w_turn ? w_pend_dir : r_dir;

    object_step_calc #(
        .OBJECT_WIDTH_X  (OBJECT_WIDTH_X),
        .OBJECT_HEIGHT_Y (OBJECT_HEIGHT_Y),
        .SPEED           (SPEED),
        .SCREEN_W        (SCREEN_W),
        .SCREEN_H        (SCREEN_H)
    ) u_step (
        .i_x         (r_x),
        .i_y         (r_y),
        .i_dir       (w_step_dir),
        .o_x_c       (w_step_x),
        .o_y_c       (w_step_y),
        .o_wrapped_c (w_wrapped),
        .o_clamped_c (w_clamped)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_x          <= POS_W'(INIT_X);
            r_y          <= POS_W'(INIT_Y);
            r_px         <= POS_W'(INIT_X);
            r_py         <= POS_W'(INIT_Y);
            r_dir        <= DIR_LEFT;
            r_pend_dir   <= DIR_LEFT;
            r_pend_valid <= 1'b0;
            r_flag       <= 1'b0;
            r_hit        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_px         <= w_px_nxt;
            r_py         <= w_py_nxt;
            r_dir        <= w_dir_nxt;
            r_pend_dir   <= w_pend_dir_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_flag       <= w_flag_nxt;
            r_hit        <= w_hit_nxt;
        end
    end

    // Next-state and frame-update logic
    always_comb begin
        w_state_nxt      = r_state;
        w_x_nxt          = r_x;
        w_y_nxt          = r_y;
        w_px_nxt         = r_px;
        w_py_nxt         = r_py;
        w_dir_nxt        = r_dir;
        w_pend_dir_nxt   = w_pend_dir;
        w_pend_valid_nxt = w_pend_valid;
        w_flag_nxt       = w_flag;
        w_hit_nxt        = 1'b0;

        if (!bus.enable) begin
            w_flag_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pend_valid) begin
                        w_dir_nxt        = w_pend_dir;
                        w_pend_valid_nxt = 1'b0;
                        w_state_nxt      = S_MOVE;
                    end
                end
                S_MOVE, S_BLOCKED: begin
                    if (bus.start_of_frame) begin
                        w_flag_nxt = 1'b0;
                        if (w_flag) begin
                            w_x_nxt     = r_px;
                            w_y_nxt     = r_py;
                            w_hit_nxt   = 1'b1;
                            w_state_nxt = S_BLOCKED;
                        end else begin
                            if (w_turn) begin
                                w_dir_nxt        = w_pend_dir;
                                w_pend_valid_nxt = 1'b0;
                            end
                            if ((r_state == S_MOVE) || w_turn) begin
                                w_x_nxt     = w_step_x;
                                w_y_nxt     = w_step_y;
                                // Never revert back across the tunnel
                                w_px_nxt    = w_wrapped ? w_step_x : r_x;
                                w_py_nxt    = r_y;
                                w_state_nxt = w_clamped ? S_BLOCKED : S_MOVE;
                            end
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.top_left_x = r_x;
    assign bus.top_left_y = r_y;
    assign bus.cur_dir    = r_dir;
    assign bus.moving     = (r_state == S_MOVE);
    assign bus.hit_pulse  = r_hit;

endmodule

// File: tb/tb_object_mover.sv
// Directed bench for object_mover: a per-cycle vector table for turns,
// collision revert and enable gating, then hand sequences for clamp,
// tunnel wrap, same-cycle collision and asynchronous reset.
module tb_object_mover;
    import object_pkg::*;

    typedef struct {
        logic              en;
        logic              sof;
        logic              col;
        dir_t              req;
        logic              rv;
        logic signed [10:0] x;
        logic signed [10:0] y;
        dir_t              dir;
        logic              mov;
        logic              hit;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   n_tab;
    vec_t vecs[32];

    object_mover_if bus ();

    object_mover dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic en, input logic sof, input logic col,
                       input dir_t req, input logic rv,
                       input logic signed [10:0] x, input logic signed [10:0] y,
                       input dir_t dir, input logic mov, input logic hit);
        vecs[n_tab].en  = en;
        vecs[n_tab].sof = sof;
        vecs[n_tab].col = col;
        vecs[n_tab].req = req;
        vecs[n_tab].rv  = rv;
        vecs[n_tab].x   = x;
        vecs[n_tab].y   = y;
        vecs[n_tab].dir = dir;
        vecs[n_tab].mov = mov;
        vecs[n_tab].hit = hit;
        n_tab++;
    endtask

    // Drive one cycle of inputs at the falling edge; sample just after the rising edge
    task automatic step(input logic en, input logic sof, input logic col,
                        input dir_t req, input logic rv);
        @(negedge clk);
        bus.enable         = en;
        bus.start_of_frame = sof;
        bus.collision      = col;
        bus.dir_req        = req;
        bus.dir_req_valid  = rv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic signed [10:0] x, input logic signed [10:0] y,
                         input dir_t dir, input logic mov, input logic hit);
        n_vec++;
        if (bus.top_left_x !== x || bus.top_left_y !== y || bus.cur_dir !== dir ||
            bus.moving !== mov || bus.hit_pulse !== hit) begin
            n_err++;
            $display("FAIL %s: got x=%0d y=%0d dir=%0d mov=%0b hit=%0b, want x=%0d y=%0d dir=%0d mov=%0b hit=%0b",
                     name, bus.top_left_x, bus.top_left_y, bus.cur_dir, bus.moving, bus.hit_pulse,
                     x, y, dir, mov, hit);
        end
    endtask

    initial begin
        logic signed [10:0] ex;
        logic signed [10:0] ey;
        n_vec = 0;
        n_err = 0;
        n_tab = 0;

        //   en    sof   col   req        rv      x         y         dir        mov   hit
        add(1'b1, 1'b0, 1'b0, DIR_RIGHT, 1'b1, 11'sd304, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, DIR_UP,    1'b0, 11'sd306, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, DIR_UP,    1'b0, 11'sd306, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, DIR_UP,    1'b0, 11'sd308, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, DIR_UP,    1'b0, 11'sd310, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, DIR_UP,    1'b1, 11'sd310, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, DIR_UP,    1'b0, 11'sd312, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, DIR_UP,    1'b0, 11'sd314, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, DIR_UP,    1'b0, 11'sd316, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, DIR_UP,    1'b0, 11'sd318, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, DIR_UP,    1'b0, 11'sd320, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, DIR_UP,    1'b0, 11'sd320, 11'sd350, DIR_UP,    1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, DIR_DOWN,  1'b1, 11'sd320, 11'sd352, DIR_DOWN,  1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, DIR_UP,    1'b0, 11'sd320, 11'sd352, DIR_DOWN,  1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, DIR_RIGHT, 1'b1, 11'sd320, 11'sd352, DIR_DOWN,  1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, DIR_UP,    1'b0, 11'sd322, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, DIR_UP,    1'b0, 11'sd322, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, DIR_UP,    1'b0, 11'sd322, 11'sd352, DIR_RIGHT, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, DIR_UP,    1'b0, 11'sd320, 11'sd352, DIR_RIGHT, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0, DIR_UP,    1'b0, 11'sd320, 11'sd352, DIR_RIGHT, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, DIR_UP,    1'b0, 11'sd320, 11'sd352, DIR_RIGHT, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, DIR_DOWN,  1'b1, 11'sd320, 11'sd352, DIR_RIGHT, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, DIR_UP,    1'b0, 11'sd320, 11'sd352, DIR_RIGHT, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, DIR_UP,    1'b0, 11'sd320, 11'sd352, DIR_DOWN,  1'b1, 1'b0);

        bus.enable         = 1'b0;
        bus.start_of_frame = 1'b0;
        bus.collision      = 1'b0;
        bus.dir_req        = DIR_UP;
        bus.dir_req_valid  = 1'b0;
        reset              = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 11'sd304, 11'sd352, DIR_LEFT, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < n_tab; i++) begin
            step(vecs[i].en, vecs[i].sof, vecs[i].col, vecs[i].req, vecs[i].rv);
            check($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].dir, vecs[i].mov, vecs[i].hit);
        end

        // Run down to the bottom edge, then one clamped step
        for (int i = 0; i < 56; i++) begin
            step(1'b1, 1'b1, 1'b0, DIR_UP, 1'b0);
            ey = 11'(352 + 2 * (i + 1));
            check("down_run", 11'sd320, ey, DIR_DOWN, 1'b1, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, DIR_UP, 1'b0);
        check("y_clamp", 11'sd320, 11'sd464, DIR_DOWN, 1'b0, 1'b0);

        // Turn out of the blocked state at an aligned tile and run to the right edge
        step(1'b1, 1'b1, 1'b0, DIR_RIGHT, 1'b1);
        check("unblock_turn", 11'sd322, 11'sd464, DIR_RIGHT, 1'b1, 1'b0);
        for (int i = 0; i < 158; i++) begin
            step(1'b1, 1'b1, 1'b0, DIR_UP, 1'b0);
            ex = 11'(322 + 2 * (i + 1));
            check("right_run", ex, 11'sd464, DIR_RIGHT, 1'b1, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, DIR_UP, 1'b0);
        check("wrap_right", -11'sd16, 11'sd464, DIR_RIGHT, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, DIR_LEFT, 1'b1);
        check("wrap_left", 11'sd638, 11'sd464, DIR_LEFT, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, DIR_UP, 1'b0);
        check("left_step", 11'sd636, 11'sd464, DIR_LEFT, 1'b1, 1'b0);

        // Collision arriving with the frame pulse reverts in that same update
        step(1'b1, 1'b1, 1'b1, DIR_UP, 1'b0);
        check("col_with_sof", 11'sd638, 11'sd464, DIR_LEFT, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, DIR_UP, 1'b0);
        check("hit_one_cycle", 11'sd638, 11'sd464, DIR_LEFT, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, DIR_UP, 1'b0);
        check("blocked_hold", 11'sd638, 11'sd464, DIR_LEFT, 1'b0, 1'b0);

        // Mid-frame reset with a pending request and a set collision flag
        step(1'b1, 1'b0, 1'b0, DIR_UP, 1'b1);
        check("pend_latched", 11'sd638, 11'sd464, DIR_LEFT, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, DIR_UP, 1'b0);
        check("flag_set", 11'sd638, 11'sd464, DIR_LEFT, 1'b0, 1'b0);
        @(negedge clk);
        bus.collision = 1'b0;
        reset         = 1'b1;
        #1;
        check("async_reset", 11'sd304, 11'sd352, DIR_LEFT, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, DIR_UP, 1'b0);
            check("post_reset_idle", 11'sd304, 11'sd352, DIR_LEFT, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
